// File: rtl/vga_grid_renderer.sv
// Pixel stage after the VGA timing controller: draws an 8x8 board of coloured cells with
// grid lines and a blinking cursor, two-cycle latency with sync/blank re-timed to match.
module vga_grid_renderer #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int CELL_W  = 80,
  parameter int CELL_H  = 60,
  parameter int COLS    = 8,
  parameter int ROWS    = 8,
  parameter int CUR_W   = 4,
  parameter int BLINK_B = 5
) (
  input  logic       vgaclk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_row,
  input  logic [1:0] wr_data,
  input  logic [2:0] cur_col,
  input  logic [2:0] cur_row,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       sync_b_o,
  output logic       blank_b_o,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int OXW = $clog2(CELL_W);
  localparam int OYW = $clog2(CELL_H);

  typedef enum logic {
    WR_EMPTY = 1'b0,
    WR_FULL  = 1'b1
  } wr_state_t;

  // Stage 1 registers
  logic           hs1, vs1, blank1, vis1;
  logic [9:0]     y1;
  logic [2:0]     col1, row1;
  logic [OXW-1:0] ox1;
  logic [OYW-1:0] oy1;

  // Board, frame counter, write holding register
  logic [1:0]     cells [COLS*ROWS];
  logic [7:0]     frame_cnt;
  wr_state_t      wr_state, wr_state_n;
  logic           wr_accept, wr_commit;
  logic [2:0]     hold_col, hold_row;
  logic [1:0]     hold_data;

  // Stage 2 combinational colour
  logic           in_vblank;
  logic           cur_cell, cur_edge, blink_on, cur_hit, grid_hit;
  logic [1:0]     cell_idx;
  logic [23:0]    rgb_n;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      blank1 <= 1'b0;
      vis1   <= 1'b0;
      y1     <= '0;
      col1   <= '0;
      row1   <= '0;
      ox1    <= '0;
      oy1    <= '0;
    end else begin
      hs1    <= hsync;
      vs1    <= vsync;
      blank1 <= blank_b;
      vis1   <= blank_b && (x < 10'(HACTIVE)) && (y < 10'(VACTIVE));
      y1     <= y;
      col1   <= 3'(x / 10'(CELL_W));
      row1   <= 3'(y / 10'(CELL_H));
      ox1    <= OXW'(x % 10'(CELL_W));
      oy1    <= OYW'(y % 10'(CELL_H));
    end
  end

  assign in_vblank = (y1 >= 10'(VACTIVE));

  // Frame counter ticks as stage 1 enters the first line of vertical blank.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if ((y1 == 10'(VACTIVE - 1)) && (y == 10'(VACTIVE))) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Write port: a transfer happens on a cycle where wr_valid and wr_ready are both high;
  // while wr_ready is low the requester keeps wr_valid and its col/row/data stable.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      wr_state <= WR_EMPTY;
    end else begin
      wr_state <= wr_state_n;
    end
  end

  always_comb begin
    wr_state_n = wr_state;
    wr_accept  = 1'b0;
    wr_commit  = 1'b0;
    case (wr_state)
      WR_EMPTY: begin
        if (wr_valid) begin
          wr_accept  = 1'b1;
          wr_state_n = WR_FULL;
        end
      end
      WR_FULL: begin
        if (in_vblank) begin
          wr_commit  = 1'b1;
          wr_state_n = WR_EMPTY;
        end
      end
      default: wr_state_n = WR_EMPTY;
    endcase
  end

  assign wr_ready = (wr_state == WR_EMPTY);

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hold_col  <= '0;
      hold_row  <= '0;
      hold_data <= '0;
    end else if (wr_accept) begin
      hold_col  <= wr_col;
      hold_row  <= wr_row;
      hold_data <= wr_data;
    end
  end

  // Commits only land during vertical blank so a frame never shows a half-updated board.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      for (int i = 0; i < COLS*ROWS; i++) begin
        cells[i] <= '0;
      end
    end else if (wr_commit) begin
      cells[{hold_row, hold_col}] <= hold_data;
    end
  end

  always_comb begin
    cell_idx = cells[{row1, col1}];
    blink_on = (frame_cnt[BLINK_B] == 1'b0);
    cur_cell = (col1 == cur_col) && (row1 == cur_row);
    cur_edge = (ox1 < OXW'(CUR_W)) || (ox1 >= OXW'(CELL_W - CUR_W)) ||
               (oy1 < OYW'(CUR_W)) || (oy1 >= OYW'(CELL_H - CUR_W));
    cur_hit  = cur_cell && blink_on && cur_edge;
    grid_hit = (ox1 == '0) || (oy1 == '0);
    rgb_n    = 24'h000000;
    if (!vis1) begin
      rgb_n = 24'h000000;
    end else if (cur_hit) begin
      rgb_n = 24'hFFFF00;
    end else if (grid_hit) begin
      rgb_n = 24'hFFFFFF;
    end else begin
      case (cell_idx)
        2'd0:    rgb_n = 24'h000000;
        2'd1:    rgb_n = 24'hFF0000;
        2'd2:    rgb_n = 24'h0000FF;
        default: rgb_n = 24'h00FF00;
      endcase
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hsync_o   <= 1'b1;
      vsync_o   <= 1'b1;
      blank_b_o <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else begin
      hsync_o   <= hs1;
      vsync_o   <= vs1;
      blank_b_o <= blank1;
      r         <= rgb_n[23:16];
      g         <= rgb_n[15:8];
      b         <= rgb_n[7:0];
    end
  end

  assign sync_b_o = hsync_o & vsync_o;

endmodule
